// File: rtl/pulse_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pulse_stream_arbiter
// Purpose  : Round-robin sharing of one pulse output between CHANNEL_COUNT
//            synchronous pulse sources. Sources are switched only while the
//            selected stream is inactive, so no pulse is truncated and no
//            runt pulse is produced. Each grant lasts a programmable number
//            of complete pulses (0 = unlimited).
// Ports    : clock            - sole clock, rising edge
//            reset_n          - asynchronous active-low reset
//            clock_enable     - freezes all state when low
//            requests         - level request per source
//            pulses_in        - pulse stream per source
//            pulses_per_grant - per-grant pulse quota, sampled at grant
//            grant            - registered one-hot selected channel
//            gate_open        - registered, high while selected stream passes
//            pulses_out       - gated copy of the selected stream
// Revision : 1.0 - initial release
// ============================================================================
module pulse_stream_arbiter #(
  parameter int   CHANNEL_COUNT      = 4,
  parameter logic PULSE_ACTIVE_LEVEL = 1'b1,
  parameter int   PULSE_COUNT_WIDTH  = 8
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         clock_enable,
  input  logic [CHANNEL_COUNT-1:0]     requests,
  input  logic [CHANNEL_COUNT-1:0]     pulses_in,
  input  logic [PULSE_COUNT_WIDTH-1:0] pulses_per_grant,
  output logic [CHANNEL_COUNT-1:0]     grant,
  output logic                         gate_open,
  output logic                         pulses_out
);

  localparam int IDX_W = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNEL_COUNT - 1);
  localparam logic INACTIVE_LEVEL = ~PULSE_ACTIVE_LEVEL;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_OPEN  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t                         state, state_nx;
  logic [CHANNEL_COUNT-1:0]       grant_nx;
  logic                           gate_nx;
  logic [PULSE_COUNT_WIDTH-1:0]   count, count_nx;
  logic [PULSE_COUNT_WIDTH-1:0]   quota, quota_nx;
  logic [IDX_W-1:0]               last_granted, last_nx;
  logic                           prev_sample, prev_nx;

  // Round-robin search helpers
  logic                           found;
  logic [IDX_W-1:0]               pick_idx;
  logic [IDX_W-1:0]               cand;

  // Selected-channel views; last_granted is the selected index while granted
  logic                           sel_in;
  logic                           sel_req;
  logic                           in_active;
  logic                           completion;
  logic [PULSE_COUNT_WIDTH:0]     count_sum;
  logic                           quota_hit;
  logic                           close_now;

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                 input int offset);
    int s;
    s = (int'(base) + offset) % CHANNEL_COUNT;
    return s[IDX_W-1:0];
  endfunction

  // First requester strictly after last_granted, wrapping around
  always_comb begin
    found    = 1'b0;
    pick_idx = last_granted;
    cand     = last_granted;
    for (int k = 1; k <= CHANNEL_COUNT; k++) begin
      cand = wrap_idx(last_granted, k);
      if (!found && requests[cand]) begin
        found    = 1'b1;
        pick_idx = cand;
      end
    end
  end

  assign sel_in     = pulses_in[last_granted];
  assign sel_req    = requests[last_granted];
  assign in_active  = (sel_in == PULSE_ACTIVE_LEVEL);
  // Complete pulse: active last sample, inactive now
  assign completion = (prev_sample == PULSE_ACTIVE_LEVEL) && !in_active;
  // One extra bit so count+completion cannot wrap before the compare
  assign count_sum  = {1'b0, count} + {{PULSE_COUNT_WIDTH{1'b0}}, completion};
  assign quota_hit  = (quota != '0) && (count_sum == {1'b0, quota});
  assign close_now  = !sel_req || quota_hit;

  always_comb begin
    state_nx = state;
    grant_nx = grant;
    gate_nx  = gate_open;
    count_nx = count;
    quota_nx = quota;
    last_nx  = last_granted;
    prev_nx  = prev_sample;
    case (state)
      S_IDLE: begin
        grant_nx = '0;
        gate_nx  = 1'b0;
        if (found) begin
          grant_nx           = '0;
          grant_nx[pick_idx] = 1'b1;
          quota_nx           = pulses_per_grant;
          count_nx           = '0;
          last_nx            = pick_idx;
          state_nx           = S_ARM;
        end
      end
      S_ARM: begin
        if (!sel_req) begin
          grant_nx = '0;
          state_nx = S_IDLE;
        end else if (!in_active) begin
          // Entering between pulses: the edge detector starts from inactive
          gate_nx  = 1'b1;
          prev_nx  = INACTIVE_LEVEL;
          state_nx = S_OPEN;
        end
      end
      S_OPEN: begin
        prev_nx = sel_in;
        if (completion && (count != '1)) begin
          count_nx = count + 1'b1;
        end
        if (close_now) begin
          if (!in_active) begin
            gate_nx  = 1'b0;
            grant_nx = '0;
            state_nx = S_IDLE;
          end else begin
            state_nx = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        prev_nx = sel_in;
        if (!in_active) begin
          gate_nx  = 1'b0;
          grant_nx = '0;
          state_nx = S_IDLE;
        end
      end
      default: begin
        gate_nx  = 1'b0;
        grant_nx = '0;
        state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      grant        <= '0;
      gate_open    <= 1'b0;
      count        <= '0;
      quota        <= '0;
      last_granted <= LAST_IDX;
      prev_sample  <= INACTIVE_LEVEL;
    end else if (clock_enable) begin
      state        <= state_nx;
      grant        <= grant_nx;
      gate_open    <= gate_nx;
      count        <= count_nx;
      quota        <= quota_nx;
      last_granted <= last_nx;
      prev_sample  <= prev_nx;
    end
  end

  // Zero-latency pass-through; reset clears gate_open so the output idles at once
  assign pulses_out = gate_open ? sel_in : INACTIVE_LEVEL;

endmodule
`default_nettype wire

// File: tb/tb_pulse_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pulse_stream_arbiter
// Purpose  : Self-checking bench for pulse_stream_arbiter. Expected grants
//            (channel, number of output pulses) are queued when stimulus is
//            set up and compared when each grant ends.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pulse_stream_arbiter;

  localparam int NCH = 4;
  localparam int PW  = 8;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic            clock_enable = 1'b1;
  logic [NCH-1:0]  requests = '0;
  logic [NCH-1:0]  pulses_in = '0;
  logic [PW-1:0]   pulses_per_grant = '0;
  logic [NCH-1:0]  grant;
  logic            gate_open;
  logic            pulses_out;

  pulse_stream_arbiter #(
    .CHANNEL_COUNT     (NCH),
    .PULSE_ACTIVE_LEVEL(1'b1),
    .PULSE_COUNT_WIDTH (PW)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .clock_enable    (clock_enable),
    .requests        (requests),
    .pulses_in       (pulses_in),
    .pulses_per_grant(pulses_per_grant),
    .grant           (grant),
    .gate_open       (gate_open),
    .pulses_out      (pulses_out)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_value(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse generators: high for hi_len cycles then low for lo_len cycles
  int hi_len[NCH];
  int lo_len[NCH];
  int ph[NCH];
  bit run[NCH];

  always @(posedge clock) begin
    #2;
    for (int c = 0; c < NCH; c++) begin
      if (run[c]) begin
        pulses_in[c] = (ph[c] < hi_len[c]);
        ph[c] = (ph[c] + 1) % (hi_len[c] + lo_len[c]);
      end else begin
        pulses_in[c] = 1'b0;
      end
    end
  end

  typedef struct {
    int chan;
    int pulses;
  } exp_t;
  exp_t sb[$];

  function automatic int oh_idx(input logic [NCH-1:0] v);
    for (int i = 0; i < NCH; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Monitor: counts output pulses per grant, checks clean edges, scores grants
  bit             mon_en = 1'b0;
  logic [NCH-1:0] prev_grant = '0;
  logic           out_prev = 1'b0;
  logic [NCH-1:0] in_prev = '0;
  int             cur_pulses = 0;
  int             gi;
  exp_t           e;

  always @(negedge clock) begin
    if (mon_en) begin
      if (grant != '0) begin
        gi = oh_idx(grant);
        if (out_prev && !pulses_out) begin
          cur_pulses++;
          check_value("fall_clean", 32'(pulses_in[gi]), 32'd0);
        end
        if (!out_prev && pulses_out) begin
          check_value("rise_full", 32'(in_prev[gi]), 32'd0);
        end
      end
      if ((prev_grant != '0) && (grant != prev_grant)) begin
        if (sb.size() == 0) begin
          check_value("sb_unexpected", 32'(oh_idx(prev_grant)), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check_value("sb_chan", 32'(oh_idx(prev_grant)), 32'(e.chan));
          check_value("sb_pulses", 32'(cur_pulses), 32'(e.pulses));
        end
        cur_pulses = 0;
      end
    end else begin
      cur_pulses = 0;
    end
    prev_grant = grant;
    out_prev   = pulses_out;
    in_prev    = pulses_in;
  end

  task automatic do_reset();
    mon_en       = 1'b0;
    requests     = '0;
    clock_enable = 1'b1;
    for (int c = 0; c < NCH; c++) run[c] = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    #1;
    check_value("rst_grant", 32'(grant), 32'd0);
    check_value("rst_gate", 32'(gate_open), 32'd0);
    check_value("rst_out", 32'(pulses_out), 32'd0);
    check_value("rst_sb_empty", 32'(sb.size()), 32'd0);
    sb.delete();
    mon_en = 1'b1;
  endtask

  task automatic wait_sb_empty(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clock);
      #1;
      if (sb.size() == 0) return;
    end
    check_value("timeout_sb", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic set_gen(input int c, input int hi, input int lo, input int p);
    hi_len[c] = hi;
    lo_len[c] = lo;
    ph[c]     = p;
    run[c]    = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;

    // Two requesters, quota 2, alternate 0,2,0
    do_reset();
    set_gen(0, 2, 3, 0);
    set_gen(2, 1, 2, 0);
    pulses_per_grant = 8'd2;
    sb.push_back('{chan: 0, pulses: 2});
    sb.push_back('{chan: 2, pulses: 2});
    sb.push_back('{chan: 0, pulses: 2});
    requests = 4'b0101;
    @(negedge clock);
    #1;
    check_value("t1_first_grant", 32'(grant), 32'h1);
    wait_sb_empty(300);
    requests = '0;

    // Unlimited grant ended by request drop mid-pulse: drain then idle
    do_reset();
    set_gen(1, 1, 1, 0);
    pulses_per_grant = 8'd0;
    sb.push_back('{chan: 1, pulses: 4});
    requests = 4'b0010;
    guard = 0;
    do begin
      @(negedge clock);
      #1;
      guard++;
    end while (!(gate_open && cur_pulses == 3 && pulses_in[1]) && guard < 100);
    check_value("t2_reach_drop", 32'(guard < 100), 32'd1);
    requests = '0;
    @(negedge clock);
    #1;
    check_value("t2_drain_gate", 32'(gate_open), 32'd1);
    check_value("t2_drain_grant", 32'(grant), 32'h2);
    @(negedge clock);
    #1;
    check_value("t2_idle_grant", 32'(grant), 32'd0);
    check_value("t2_idle_gate", 32'(gate_open), 32'd0);
    wait_sb_empty(10);

    // Grant arrives mid-pulse: gate held shut until the input goes low
    do_reset();
    set_gen(3, 6, 3, 1);
    pulses_per_grant = 8'd2;
    sb.push_back('{chan: 3, pulses: 2});
    requests = 4'b1000;
    @(negedge clock);
    #1;
    check_value("t3_grant", 32'(grant), 32'h8);
    guard = 0;
    while (pulses_in[3] && guard < 20) begin
      check_value("t3_arm_hold", 32'(gate_open), 32'd0);
      @(negedge clock);
      #1;
      guard++;
    end
    check_value("t3_arm_at_low", 32'(gate_open), 32'd0);
    @(negedge clock);
    #1;
    check_value("t3_open", 32'(gate_open), 32'd1);
    wait_sb_empty(100);
    requests = '0;

    // All four requesting, one pulse each, fair rotation
    do_reset();
    for (int c = 0; c < NCH; c++) set_gen(c, 1, 1, 0);
    pulses_per_grant = 8'd1;
    sb.push_back('{chan: 0, pulses: 1});
    sb.push_back('{chan: 1, pulses: 1});
    sb.push_back('{chan: 2, pulses: 1});
    sb.push_back('{chan: 3, pulses: 1});
    sb.push_back('{chan: 0, pulses: 1});
    requests = 4'b1111;
    wait_sb_empty(300);
    requests = '0;

    // Clock enable low for 10 cycles (two input periods) during OPEN:
    // the two pulses passed while frozen are not counted toward the quota
    do_reset();
    set_gen(0, 2, 3, 0);
    pulses_per_grant = 8'd3;
    sb.push_back('{chan: 0, pulses: 5});
    requests = 4'b0001;
    guard = 0;
    do begin
      @(negedge clock);
      #1;
      guard++;
    end while (!(gate_open && cur_pulses == 1) && guard < 100);
    check_value("t5_reach_open", 32'(guard < 100), 32'd1);
    clock_enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      #1;
      check_value("t5_follow", 32'(pulses_out), 32'(pulses_in[0]));
    end
    check_value("t5_frozen_gate", 32'(gate_open), 32'd1);
    check_value("t5_frozen_grant", 32'(grant), 32'h1);
    clock_enable = 1'b1;
    wait_sb_empty(100);
    requests = '0;

    // Asynchronous reset mid-pulse, then ch0 has priority again
    do_reset();
    set_gen(0, 3, 2, 0);
    set_gen(2, 3, 2, 0);
    pulses_per_grant = 8'd0;
    requests = 4'b0100;
    guard = 0;
    do begin
      @(negedge clock);
      #1;
      guard++;
    end while (!(gate_open && pulses_out) && guard < 100);
    check_value("t6_reach_pulse", 32'(guard < 100), 32'd1);
    mon_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    check_value("t6_async_out", 32'(pulses_out), 32'd0);
    check_value("t6_async_grant", 32'(grant), 32'd0);
    check_value("t6_async_gate", 32'(gate_open), 32'd0);
    @(negedge clock);
    reset_n  = 1'b1;
    requests = 4'b1111;
    @(negedge clock);
    #1;
    check_value("t6_prio", 32'(grant), 32'h1);
    requests = '0;
    repeat (3) @(negedge clock);

    check_value("sb_left", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
